// File: rtl/uart_fifo_core_if.sv
// Byte-stream handshake between the UART core and its user.
// master = user side (drives TX words, consumes RX words), slave = UART core.
interface uart_fifo_core_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_fifo_core.sv
// UART transceiver with configurable frame format, runtime baud divisor,
// first-word fall-through RX FIFO and framing/parity/overflow reporting.
// Optional build macro UART_LOOPBACK_EN adds a 'loopback' input that routes
// the internal TX line into the RX synchroniser and parks the uart_tx pin high.
module uart_fifo_core #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned RX_AW     = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DIV_W-1:0]  baud_div,
    uart_fifo_core_if.slave   bus,
    output logic              tx_busy,
    output logic [RX_AW:0]    rx_count,
    output logic              rx_overflow,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    input  logic              err_clr,
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              uart_rx,
    output logic              uart_tx
);

    localparam int unsigned BIT_W = 4;
    localparam int unsigned CNT_W = RX_AW + 1;
    localparam int unsigned DEPTH = 1 << RX_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DIV_W-1:0] div_eff;
    logic             rx_in;

    // Divisors below 4 leave no room for a mid-bit sample; clamp them.
    assign div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

    // ------------------------------------------------------------------ TX
    state_t               tx_state;
    logic [DIV_W-1:0]     tx_cnt;
    logic [DIV_W-1:0]     tx_div;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_line;
    logic                 tx_busy_q;

    assign bus.tx_ready = (tx_state == S_IDLE) && !sys_rst;
    assign tx_busy      = tx_busy_q;

    // TX frame sequencer: every bit lasts tx_div cycles, divisor frozen per frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_div    <= DIV_W'(4);
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_line   <= 1'b1;
            tx_busy_q <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (bus.tx_valid) begin
                tx_state  <= S_START;
                tx_line   <= 1'b0;
                tx_cnt    <= '0;
                tx_div    <= div_eff;
                tx_shift  <= bus.tx_data;
                tx_par    <= (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
                tx_busy_q <= 1'b1;
            end
        end else if (tx_cnt != tx_div - DIV_W'(1)) begin
            tx_cnt <= tx_cnt + DIV_W'(1);
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    tx_line  <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= '0;
                end
                S_DATA: begin
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                        tx_bit <= '0;
                        if (PARITY != 0) begin
                            tx_state <= S_PAR;
                            tx_line  <= tx_par;
                        end else begin
                            tx_state <= S_STOP;
                            tx_line  <= 1'b1;
                        end
                    end else begin
                        tx_bit   <= tx_bit + BIT_W'(1);
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                S_PAR: begin
                    tx_state <= S_STOP;
                    tx_line  <= 1'b1;
                    tx_bit   <= '0;
                end
                S_STOP: begin
                    if (tx_bit == BIT_W'(STOP_BITS - 1)) begin
                        tx_state  <= S_IDLE;
                        tx_busy_q <= 1'b0;
                    end else begin
                        tx_bit <= tx_bit + BIT_W'(1);
                    end
                    tx_line <= 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Pin / loopback routing.
`ifdef UART_LOOPBACK_EN
    assign rx_in   = loopback ? tx_line : uart_rx;
    assign uart_tx = loopback ? 1'b1 : tx_line;
`else
    assign rx_in   = uart_rx;
    assign uart_tx = tx_line;
`endif

    // ------------------------------------------------------------------ RX
    logic [1:0]           rx_sync;
    logic                 rxs;
    logic                 rxs_d;
    state_t               rx_state;
    logic [DIV_W-1:0]     rx_cnt;
    logic [DIV_W-1:0]     rx_div;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_par_bad_c;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 push_q;

    assign rxs           = rx_sync[1];
    assign rx_frame_err  = frame_err_q;
    assign rx_parity_err = parity_err_q;

    // Received parity check against the configured polarity.
    always_comb begin
        rx_par_bad_c = 1'b0;
        if (PARITY != 0) begin
            rx_par_bad_c = ((^rx_shift) ^ rx_par_bit) != 1'(PARITY == 1);
        end
    end

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_sync <= 2'b11;
            rxs_d   <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rxs_d   <= rxs;
        end
    end

    // RX frame sequencer: qualify start at half a bit, then sample mid-bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_div       <= DIV_W'(4);
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par_bit   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            push_q       <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            push_q       <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                        rx_div   <= div_eff;
                    end
                end
                S_START: begin
                    if (rx_cnt == (rx_div >> 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == rx_div - DIV_W'(1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
                            rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + BIT_W'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                S_PAR: begin
                    if (rx_cnt == rx_div - DIV_W'(1)) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rxs;
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt == rx_div - DIV_W'(1)) begin
                        rx_cnt       <= '0;
                        rx_state     <= S_IDLE;
                        frame_err_q  <= !rxs;
                        parity_err_q <= rx_par_bad_c;
                        push_q       <= rxs && !rx_par_bad_c;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [0:DEPTH-1];
    logic [RX_AW-1:0]     wr_ptr;
    logic [RX_AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 ovf_q;
    logic                 full_c;
    logic                 pop_c;
    logic                 wr_en_c;

    assign full_c       = (fifo_cnt == CNT_W'(DEPTH));
    assign bus.rx_valid = (fifo_cnt != '0);
    assign pop_c        = bus.rx_valid && bus.rx_ready;
    assign wr_en_c      = push_q && (!full_c || pop_c);
    assign bus.rx_data  = mem[rd_ptr];
    assign rx_count     = fifo_cnt;
    assign rx_overflow  = ovf_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge sys_clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    // Pointers, occupancy and sticky overflow (a new overflow beats err_clr).
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + RX_AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + RX_AW'(1);
            end
            if (wr_en_c && !pop_c) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!wr_en_c && pop_c) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            if (push_q && full_c && !pop_c) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core (8 data bits, even parity, 1 stop bit).
module tb_uart_fifo_core;

    localparam int unsigned DB = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [DW-1:0] baud_div;
    logic          tx_busy;
    logic [AW:0]   rx_count;
    logic          rx_overflow;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          err_clr;
    logic          uart_tx;
    logic          rx_drv;
    logic          loop_ext;
    wire           uart_rx;
`ifdef UART_LOOPBACK_EN
    logic          loopback;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0, fe_cyc = 0, pe_cnt = 0, pe_cyc = 0, tx_low = 0;
    logic fe_prev = 1'b0, pe_prev = 1'b0;
    logic [DB-1:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    assign uart_rx = loop_ext ? uart_tx : rx_drv;

    uart_fifo_core_if #(.DATA_BITS(DB)) bus ();

    uart_fifo_core #(
        .DATA_BITS(DB), .STOP_BITS(1), .PARITY(2), .DIV_W(DW), .RX_AW(AW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .baud_div      (baud_div),
        .bus           (bus.slave),
        .tx_busy       (tx_busy),
        .rx_count      (rx_count),
        .rx_overflow   (rx_overflow),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .err_clr       (err_clr),
`ifdef UART_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Output monitor: pops scoreboard on every FIFO pop, counts error pulses.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rx_frame_err) begin
                fe_cyc++;
                if (!fe_prev) fe_cnt++;
            end
            if (rx_parity_err) begin
                pe_cyc++;
                if (!pe_prev) pe_cnt++;
            end
            if (!uart_tx) tx_low++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) check("unexpected_pop", 32'(bus.rx_data), 32'hFFFF_FFFF);
                else check("rx_pop", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
        end
        fe_prev = rx_frame_err;
        pe_prev = rx_parity_err;
    end

    task automatic send(input logic [DB-1:0] d);
        int n = 0;
        while (!bus.tx_ready && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    // Bit-bang one frame on uart_rx at 16 cycles per bit (even parity).
    task automatic drive_frame(input logic [DB-1:0] d, input logic bad_par, input logic stop);
        logic [10:0] fr;
        fr = {stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_drv = fr[i];
            tick(16);
        end
        rx_drv = 1'b1;
        tick(16);
    endtask

    task automatic wait_count(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(rx_count) != target && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check(tag, 32'(rx_count), 32'(target));
    endtask

    initial begin
        logic [10:0] fr;
        logic [DB-1:0] w [17];
        int fe0, pe0, fc0, pc0, low0, n;

        baud_div     = 16;
        err_clr      = 1'b0;
        rx_drv       = 1'b1;
        loop_ext     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
`ifdef UART_LOOPBACK_EN
        loopback     = 1'b0;
`endif

        // Reset state
        sys_rst = 1'b1;
        tick(4);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        sys_rst = 1'b0;
        #1;
        check("tx_ready_after_rst", 32'(bus.tx_ready), 32'd1);
        tick(2);

        // 1. TX waveform of 0xA5 and frame length
        fr = {1'b1, ^8'hA5, 8'hA5, 1'b0};
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 0; i <= 176; i++) begin
            if (i < 176 && (i % 16) == 8) check($sformatf("tx_bit%0d", i / 16), 32'(uart_tx), 32'(fr[i / 16]));
            if (i == 8)   check("tx_busy_mid", 32'(tx_busy), 32'd1);
            if (i == 175) check("tx_ready_last_stop", 32'(bus.tx_ready), 32'd0);
            if (i == 176) check("tx_ready_back", 32'(bus.tx_ready), 32'd1);
            if (i < 176) tick();
        end

        // 2. External loop: three words round trip
        loop_ext = 1'b1;
        tick(10);
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        foreach (w[i]) w[i] = '0;
        w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(w[i]);
            send(w[i]);
        end
        wait_count("loop_count_timeout", 3, 400);
        check("loop_count_peak", 32'(rx_count), 32'd3);
        check("loop_head", 32'(bus.rx_data), 32'h00);
        bus.rx_ready = 1'b1;
        wait_count("loop_drain_timeout", 0, 50);
        check("loop_fe", 32'(fe_cnt - fe0), 32'd0);
        check("loop_pe", 32'(pe_cnt - pe0), 32'd0);

        // Divisor below 4 clamps to 4: 11 bits * 4 cycles
        baud_div = 2;
        exp_q.push_back(8'h96);
        send(8'h96);
        n = 0;
        while (!bus.tx_ready && n < 200) begin
            tick();
            n++;
        end
        check("clamp_frame_len", 32'(n), 32'd44);
        tick(10);
        check("clamp_rx_drained", 32'(exp_q.size()), 32'd0);
        baud_div = 16;
        loop_ext = 1'b0;
        tick(10);

        // 3. Frame error and parity error
        bus.rx_ready = 1'b0;
        fe0 = fe_cnt; fc0 = fe_cyc; pe0 = pe_cnt; pc0 = pe_cyc;
        drive_frame(8'h81, 1'b0, 1'b0);
        check("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("fe_width", 32'(fe_cyc - fc0), 32'd1);
        check("fe_no_pe", 32'(pe_cnt - pe0), 32'd0);
        check("fe_count", 32'(rx_count), 32'd0);
        fe0 = fe_cnt;
        drive_frame(8'h42, 1'b1, 1'b1);
        check("pe_pulses", 32'(pe_cnt - pe0), 32'd1);
        check("pe_width", 32'(pe_cyc - pc0), 32'd1);
        check("pe_no_fe", 32'(fe_cnt - fe0), 32'd0);
        check("pe_count", 32'(rx_count), 32'd0);
        exp_q.push_back(8'h7E);
        drive_frame(8'h7E, 1'b0, 1'b1);
        check("good_count", 32'(rx_count), 32'd1);
        bus.rx_ready = 1'b1;
        tick(3);
        check("good_drained", 32'(rx_count), 32'd0);

        // 4. Overflow with 17 words and no pops
        bus.rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            w[i] = 8'(i * 37 + 5);
            if (i < 16) exp_q.push_back(w[i]);
            drive_frame(w[i], 1'b0, 1'b1);
            if (i == 15) check("full_no_ovf", 32'(rx_overflow), 32'd0);
        end
        check("ovf_count", 32'(rx_count), 32'd16);
        check("ovf_flag", 32'(rx_overflow), 32'd1);
        check("ovf_head", 32'(bus.rx_data), 32'(w[0]));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared", 32'(rx_overflow), 32'd0);
        bus.rx_ready = 1'b1;
        wait_count("ovf_drain_timeout", 0, 40);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // 5. Start-bit glitch, then reset in the middle of a TX frame
        bus.rx_ready = 1'b0;
        fe0 = fe_cnt; pe0 = pe_cnt;
        rx_drv = 1'b0;
        tick(6);
        rx_drv = 1'b1;
        tick(60);
        check("glitch_count", 32'(rx_count), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_pe", 32'(pe_cnt - pe0), 32'd0);
        drive_frame(8'h11, 1'b0, 1'b1);
        check("prerst_count", 32'(rx_count), 32'd1);
        send(8'hC3);
        tick(8);
        check("prerst_tx_low", 32'(uart_tx), 32'd0);
        sys_rst = 1'b1;
        tick();
        check("midrst_uart_tx", 32'(uart_tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_count", 32'(rx_count), 32'd0);
        check("midrst_valid", 32'(bus.rx_valid), 32'd0);
        sys_rst = 1'b0;
        tick(4);

`ifdef UART_LOOPBACK_EN
        // 6. Internal loopback at divisor 4, pin parked high
        loopback     = 1'b1;
        baud_div     = 4;
        bus.rx_ready = 1'b1;
        tick(4);
        low0 = tx_low;
        exp_q.push_back(8'h5A);
        send(8'h5A);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("lb_received", 32'(exp_q.size()), 32'd0);
        check("lb_pin_high", 32'(tx_low - low0), 32'd0);
        loopback = 1'b0;
        baud_div = 16;
        tick(4);
`else
        low0 = 0;
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
